fetch_sequencer: RTL

- Sequences instruction fetch for the IF stage.
- Owns the program counter and drives a req/ack instruction-memory port.
- Applies branch redirects and IF stalls, and presents fetched Instruction/ProgramCounter plus a valid flag to the ID stage.
- Replaces free-running PC logic, so multi-cycle program memory and redirects during an in-flight fetch are handled cleanly.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_sequencer_if.sv | 43 ++++
 rtl/fetch_skid_buf.sv | 38 +++
 rtl/fetch_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the IF-stage fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, skid-buffer entry struct, parameter defaults.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEF      = 32'd4;
  localparam logic [31:0] NOP_WORD_DEF     = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of IF-stage signals: redirect/stall controls, imem req/ack port, ID-facing outputs.
// Latency: n/a (wiring only).
// Backpressure: MemReq is held until MemAck; IF_StallReq freezes the ID-facing outputs.
// Modports: master = sequencer side, slave = environment (core control, memory, ID stage).
// Optional FETCH_PERF_CNT_EN adds StallCycles[31:0] and FlushCount[15:0].
interface fetch_sequencer_if;

  logic [31:0] BranchAddress;
  logic        BranchSelection;
  logic        IF_StallReq;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;
  logic [31:0] Instruction;
  logic [31:0] ProgramCounter;
  logic        InstrValid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] StallCycles;
  logic [15:0] FlushCount;

  modport master (
    input  BranchAddress, BranchSelection, IF_StallReq, MemAck, MemData,
    output MemReq, MemAddr, Instruction, ProgramCounter, InstrValid,
    output StallCycles, FlushCount
  );
  modport slave (
    output BranchAddress, BranchSelection, IF_StallReq, MemAck, MemData,
    input  MemReq, MemAddr, Instruction, ProgramCounter, InstrValid,
    input  StallCycles, FlushCount
  );
`else
  modport master (
    input  BranchAddress, BranchSelection, IF_StallReq, MemAck, MemData,
    output MemReq, MemAddr, Instruction, ProgramCounter, InstrValid
  );
  modport slave (
    output BranchAddress, BranchSelection, IF_StallReq, MemAck, MemData,
    input  MemReq, MemAddr, Instruction, ProgramCounter, InstrValid
  );
`endif

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {PC, instruction} holding register for a fetch that completes during a stall.
// Latency: entry visible on entry_o the cycle after load_i.
// Backpressure: full_o tells the owner to stop issuing; clear_i beats load_i beats pop_i.
// Ports: clk_i, rst_ni (sync active-low), load_i/pop_i/clear_i, entry_i -> full_o, entry_o.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  fetch_entry_t entry_i,
  output logic         full_o,
  output fetch_entry_t entry_o
);

  logic         full_q;
  fetch_entry_t entry_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else if (clear_i) begin
      full_q  <= 1'b0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      entry_q <= entry_i;
    end else if (pop_i) begin
      full_q  <= 1'b0;
    end
  end

  assign full_o  = full_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the PC, drives imem req/ack, applies redirects and stalls.
// Latency: 1 cycle from MemAck to Instruction/ProgramCounter/InstrValid; 1 instr/cycle at zero wait.
// Backpressure: IF_StallReq holds outputs, one ack during a stall lands in a skid buffer, then no new request.
// Ports: ClockInput, ResetInputN (sync active-low), bus (fetch_sequencer_if.master).
// Optional FETCH_PERF_CNT_EN: saturating StallCycles / FlushCount on the bus.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] PC_STEP      = PC_STEP_DEF,
  parameter logic [31:0] NOP_WORD     = NOP_WORD_DEF
) (
  input  logic              ClockInput,
  input  logic              ResetInputN,
  fetch_sequencer_if.master bus
);

  fetch_state_e state_q;
  logic         mem_req_q;
  logic [31:0]  mem_addr_q;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  instr_q, pc_q;
  logic         valid_q;

  logic         ack, pending, branch, stall;
  logic         buf_load, buf_pop, buf_full;
  fetch_entry_t buf_entry;

  // An ack only counts while a request is actually outstanding.
  assign ack     = mem_req_q &  bus.MemAck;
  assign pending = mem_req_q & ~bus.MemAck;
  assign branch  = bus.BranchSelection;
  assign stall   = bus.IF_StallReq;

  assign buf_load = ~branch & (state_q == FETCH) & ack & stall;
  assign buf_pop  = ~branch & (state_q == HOLD) & ~stall;

  fetch_skid_buf u_skid (
    .clk_i   (ClockInput),
    .rst_ni  (ResetInputN),
    .load_i  (buf_load),
    .pop_i   (buf_pop),
    .clear_i (branch),
    .entry_i ('{pc: fetch_pc_q, instr: bus.MemData}),
    .full_o  (buf_full),
    .entry_o (buf_entry)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (branch) begin
      fetch_pc_d = BranchAddress_unused_guard(bus.BranchAddress);
    end else if ((state_q == FETCH) && ack) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  function automatic logic [31:0] BranchAddress_unused_guard(input logic [31:0] a);
    return a;
  endfunction

  always_ff @(posedge ClockInput) begin
    if (!ResetInputN) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_VECTOR;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_VECTOR;
      instr_q    <= NOP_WORD;
      pc_q       <= RESET_VECTOR;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      // The address only moves once the current request has finished, so it
      // stays stable across wait states and while draining a redirected fetch.
      if (!pending) begin
        mem_addr_q <= fetch_pc_d;
      end

      if (branch) begin
        valid_q   <= 1'b0;
        instr_q   <= NOP_WORD;
        mem_req_q <= 1'b1;
        state_q   <= pending ? DRAIN : FETCH;
      end else begin
        case (state_q)
          BOOT: begin
            state_q   <= FETCH;
            mem_req_q <= 1'b1;
          end
          FETCH: begin
            if (ack && stall) begin
              state_q   <= HOLD;
              mem_req_q <= 1'b0;
            end else if (ack) begin
              instr_q <= bus.MemData;
              pc_q    <= fetch_pc_q;
              valid_q <= 1'b1;
            end else if (!stall) begin
              // Wait state with ID free to advance: present a bubble, keep the PC.
              valid_q <= 1'b0;
              instr_q <= NOP_WORD;
            end
          end
          DRAIN: begin
            if (ack) begin
              state_q <= FETCH;
            end
          end
          HOLD: begin
            if (!stall) begin
              state_q   <= FETCH;
              mem_req_q <= 1'b1;
              if (buf_full) begin
                instr_q <= buf_entry.instr;
                pc_q    <= buf_entry.pc;
                valid_q <= 1'b1;
              end else begin
                instr_q <= NOP_WORD;
                valid_q <= 1'b0;
              end
            end
          end
          default: state_q <= BOOT;
        endcase
      end
    end
  end

  assign bus.MemReq         = mem_req_q;
  assign bus.MemAddr        = mem_addr_q;
  assign bus.Instruction    = instr_q;
  assign bus.ProgramCounter = pc_q;
  assign bus.InstrValid     = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge ClockInput) begin
    if (!ResetInputN) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.StallCycles = stall_cnt_q;
  assign bus.FlushCount  = flush_cnt_q;
`endif

endmodule
